// File: rtl/nonce_search_ctrl.sv
// Proof-of-work sequencer: latches header and target, walks the nonce space
// one hash-core transaction at a time, and stops on the first hit or at MAX_NONCE.
module nonce_search_ctrl #(
   parameter int unsigned        BYTE      = 8,
   parameter int unsigned        NONCE_W   = 32,
   parameter int unsigned        HASH_W    = 24,
   parameter logic [NONCE_W-1:0] MAX_NONCE = {NONCE_W{1'b1}}
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [BYTE*12-1:0]        data_in,
   input  logic [BYTE-1:0]           target,
   output logic                      core_start,
   output logic [BYTE*12+NONCE_W-1:0] core_block,
   input  logic                      core_done,
   input  logic [HASH_W-1:0]         core_hash,
   output logic                      busy,
   output logic                      finished,
   output logic                      found,
   output logic [NONCE_W-1:0]        nonce_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [BYTE*12-1:0]   r_header;
   logic [BYTE-1:0]      r_target;
   logic [NONCE_W-1:0]   r_nonce;
   logic [HASH_W-1:0]    r_hash;
   logic                 r_core_start;
   logic                 r_busy;
   logic                 r_finished;
   logic                 r_found;
   logic [NONCE_W-1:0]   r_nonce_out;
   logic                 w_hit;
   logic                 w_in_search;

   // A hit needs both of the two most significant hash bytes strictly below target.
   assign w_hit = (r_hash[HASH_W-1 -: BYTE] < r_target) &&
                  (r_hash[HASH_W-BYTE-1 -: BYTE] < r_target);

   assign w_in_search = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_CHECK);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_header     <= '0;
         r_target     <= '0;
         r_nonce      <= '0;
         r_hash       <= '0;
         r_core_start <= 1'b0;
         r_busy       <= 1'b0;
         r_finished   <= 1'b0;
         r_found      <= 1'b0;
         r_nonce_out  <= '0;
      end else begin
         r_core_start <= 1'b0;
         if (abort && w_in_search) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_header     <= data_in;
                     r_target     <= target;
                     r_nonce      <= '0;
                     r_found      <= 1'b0;
                     r_core_start <= 1'b1;
                     r_busy       <= 1'b1;
                     r_state      <= S_ISSUE;
                  end
               end
               S_ISSUE: r_state <= S_WAIT;
               S_WAIT: begin
                  if (core_done) begin
                     r_hash  <= core_hash;
                     r_state <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (w_hit) begin
                     r_found     <= 1'b1;
                     r_nonce_out <= r_nonce;
                     r_finished  <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= S_DONE;
                  end else if (r_nonce == MAX_NONCE) begin
                     r_found     <= 1'b0;
                     r_nonce_out <= MAX_NONCE;
                     r_finished  <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= S_DONE;
                  end else begin
                     r_nonce      <= r_nonce + 1'b1;
                     r_core_start <= 1'b1;
                     r_state      <= S_ISSUE;
                  end
               end
               S_DONE: begin
                  // Only a falling start re-arms the controller.
                  if (!start) begin
                     r_finished <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign core_start = r_core_start;
   assign core_block = {r_header, r_nonce};
   assign busy       = r_busy;
   assign finished   = r_finished;
   assign found      = r_found;
   assign nonce_out  = r_nonce_out;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: two instances (MAX_NONCE 7 and 3) driven by
// behavioural hash-core models, checked against a first-hit search model.
module tb_nonce_search_ctrl;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          abort = 1'b0;
   logic [95:0]   data_in = '0;
   logic [7:0]    target = '0;
   logic          start_a = 1'b0, start_b = 1'b0;
   logic          spur_a = 1'b0;
   logic          core_start_a, core_start_b;
   logic [127:0]  core_block_a, core_block_b;
   logic          core_done_a = 1'b0, core_done_b = 1'b0;
   logic          w_done_a;
   logic [23:0]   core_hash_a = '0, core_hash_b = '0;
   logic          busy_a, busy_b, finished_a, finished_b, found_a, found_b;
   logic [31:0]   nonce_out_a, nonce_out_b;

   logic [23:0]   hash_tab [8];
   int unsigned   lat = 4;
   logic [95:0]   hdr_exp = '0;
   int unsigned   pulses_a = 0, pulses_b = 0, base_a = 0, base_b = 0;
   int unsigned   bad_a = 0, bad_b = 0, cnt_a = 0, cnt_b = 0;
   logic [31:0]   held_a = '0, held_b = '0;
   int unsigned   checks = 0, errors = 0;
   logic [31:0]   last_nonce_out;

   assign w_done_a = core_done_a | spur_a;

   always #5 clk = ~clk;

   nonce_search_ctrl #(.BYTE(8), .NONCE_W(32), .HASH_W(24), .MAX_NONCE(32'd7)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort), .data_in(data_in),
      .target(target), .core_start(core_start_a), .core_block(core_block_a),
      .core_done(w_done_a), .core_hash(core_hash_a), .busy(busy_a),
      .finished(finished_a), .found(found_a), .nonce_out(nonce_out_a));

   nonce_search_ctrl #(.BYTE(8), .NONCE_W(32), .HASH_W(24), .MAX_NONCE(32'd3)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort), .data_in(data_in),
      .target(target), .core_start(core_start_b), .core_block(core_block_b),
      .core_done(core_done_b), .core_hash(core_hash_b), .busy(busy_b),
      .finished(finished_b), .found(found_b), .nonce_out(nonce_out_b));

   // Hash core models: fixed latency, hash looked up by nonce; protocol slips counted in bad_*.
   always @(posedge clk) begin
      core_done_a <= 1'b0;
      if (reset) begin
         cnt_a <= 0;
      end else if (core_start_a) begin
         pulses_a <= pulses_a + 1;
         held_a   <= core_block_a[31:0];
         if (core_block_a[31:0] != 32'(pulses_a - base_a) || core_block_a[127:32] != hdr_exp)
            bad_a <= bad_a + 1;
         if (lat == 1) begin
            core_done_a <= 1'b1;
            core_hash_a <= hash_tab[core_block_a[2:0]];
         end else begin
            cnt_a <= lat - 1;
         end
      end else if (cnt_a != 0) begin
         cnt_a <= cnt_a - 1;
         if (core_block_a[31:0] != held_a) bad_a <= bad_a + 1;
         if (cnt_a == 1) begin
            core_done_a <= 1'b1;
            core_hash_a <= hash_tab[held_a[2:0]];
         end
      end
   end

   always @(posedge clk) begin
      core_done_b <= 1'b0;
      if (reset) begin
         cnt_b <= 0;
      end else if (core_start_b) begin
         pulses_b <= pulses_b + 1;
         held_b   <= core_block_b[31:0];
         if (core_block_b[31:0] != 32'(pulses_b - base_b) || core_block_b[127:32] != hdr_exp)
            bad_b <= bad_b + 1;
         if (lat == 1) begin
            core_done_b <= 1'b1;
            core_hash_b <= hash_tab[core_block_b[2:0]];
         end else begin
            cnt_b <= lat - 1;
         end
      end else if (cnt_b != 0) begin
         cnt_b <= cnt_b - 1;
         if (core_block_b[31:0] != held_b) bad_b <= bad_b + 1;
         if (cnt_b == 1) begin
            core_done_b <= 1'b1;
            core_hash_b <= hash_tab[held_b[2:0]];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: first nonce whose top two hash bytes are both below target, else maxn+1.
   function automatic int unsigned ref_first_hit(input logic [7:0] tgt, input int unsigned maxn);
      for (int unsigned n = 0; n <= maxn; n++)
         if (hash_tab[n][23:16] < tgt && hash_tab[n][15:8] < tgt) return n;
      return maxn + 1;
   endfunction

   task automatic fill_tab(input logic [23:0] v);
      for (int i = 0; i < 8; i++) hash_tab[i] = v;
   endtask

   task automatic launch(input bit sel, input logic [95:0] hdr, input logic [7:0] tgt,
                         input bit hold, input string tag);
      data_in = hdr;
      target  = tgt;
      hdr_exp = hdr;
      if (sel) begin base_b = pulses_b; start_b = 1'b1; end
      else     begin base_a = pulses_a; start_a = 1'b1; end
      step();
      chk({tag, "_start_lat"}, sel ? core_start_b : core_start_a, 1);
      chk({tag, "_busy"}, sel ? busy_b : busy_a, 1);
      data_in = {$urandom, $urandom, $urandom};
      target  = 8'($urandom);
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
   endtask

   task automatic search(input bit sel, input logic [95:0] hdr, input logic [7:0] tgt,
                         input bit hold, input string tag);
      int unsigned maxn, r, exp_n, n, bad0;
      bit          exp_f;
      maxn  = sel ? 3 : 7;
      r     = ref_first_hit(tgt, maxn);
      exp_f = (r <= maxn);
      exp_n = exp_f ? r : maxn;
      bad0  = sel ? bad_b : bad_a;
      launch(sel, hdr, tgt, hold, tag);
      n = 0;
      while (!(sel ? finished_b : finished_a) && n < 3000) begin step(); n++; end
      chk({tag, "_finished"}, sel ? finished_b : finished_a, 1);
      chk({tag, "_found"}, sel ? found_b : found_a, exp_f);
      chk({tag, "_nonce_out"}, sel ? nonce_out_b : nonce_out_a, exp_n);
      chk({tag, "_pulses"}, sel ? pulses_b - base_b : pulses_a - base_a, exp_n + 1);
      chk({tag, "_core_block"}, (sel ? bad_b : bad_a) - bad0, 0);
      last_nonce_out = exp_n;
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            step();
            chk({tag, "_hold_finished"}, sel ? finished_b : finished_a, 1);
         end
         chk({tag, "_hold_norelaunch"}, sel ? pulses_b - base_b : pulses_a - base_a, exp_n + 1);
         start_a = 1'b0;
         start_b = 1'b0;
         step();
         step();
      end else begin
         repeat (6) step();
      end
      chk({tag, "_idle_finished"}, sel ? finished_b : finished_a, 0);
      chk({tag, "_idle_busy"}, sel ? busy_b : busy_a, 0);
      chk({tag, "_no_extra_pulse"}, sel ? pulses_b - base_b : pulses_a - base_a, exp_n + 1);
   endtask

   task automatic main_tab();
      fill_tab(24'hFFFFFF);
      hash_tab[5] = 24'h102000;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_core_start"}, core_start_a, 0);
      chk({tag, "_core_block"}, core_block_a, 0);
      chk({tag, "_busy"}, busy_a, 0);
      chk({tag, "_finished"}, finished_a, 0);
      chk({tag, "_found"}, found_a, 0);
      chk({tag, "_nonce_out"}, nonce_out_a, 0);
   endtask

   initial begin
      int unsigned n;
      fill_tab(24'hFFFFFF);
      reset = 1'b1;
      repeat (3) step();
      chk_zero_outputs("reset");
      reset = 1'b0;
      step();

      main_tab();
      lat = 4;
      search(1'b0, 96'h397d9f2f40ca9e6c6b1f3324, 8'd150, 1'b0, "main");

      fill_tab(24'h960000);
      search(1'b0, {$urandom, $urandom, $urandom}, 8'd150, 1'b0, "equal_byte");

      for (int i = 0; i < 8; i++) hash_tab[i] = 24'($urandom);
      search(1'b1, {$urandom, $urandom, $urandom}, 8'd0, 1'b0, "zero_target");

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 8; i++) hash_tab[i] = 24'($urandom);
         lat = $urandom_range(1, 5);
         search(1'b0, {$urandom, $urandom, $urandom}, 8'($urandom_range(1, 255)), 1'b0, "random");
      end

      // Abort in the second WAIT cycle of nonce 2, coinciding with core_done.
      fill_tab(24'hFFFFFF);
      lat = 2;
      launch(1'b0, {$urandom, $urandom, $urandom}, 8'd150, 1'b0, "abort");
      n = 0;
      while (!(core_start_a && core_block_a[31:0] == 32'd2) && n < 200) begin step(); n++; end
      chk("abort_reach_nonce2", core_start_a, 1);
      step();
      step();
      chk("abort_done_coincide", core_done_a, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", busy_a, 0);
      chk("abort_finished", finished_a, 0);
      chk("abort_found", found_a, 0);
      chk("abort_nonce_out", nonce_out_a, last_nonce_out);
      repeat (10) step();
      chk("abort_no_more_pulses", pulses_a - base_a, 3);
      chk("abort_still_idle", busy_a | finished_a, 0);

      // Reset during CHECK of nonce 3.
      lat = 4;
      launch(1'b0, {$urandom, $urandom, $urandom}, 8'd150, 1'b0, "rst_mid");
      n = 0;
      while (!(core_done_a && core_block_a[31:0] == 32'd3) && n < 200) begin step(); n++; end
      chk("rst_mid_reach_done3", core_done_a, 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_zero_outputs("rst_mid");
      spur_a = 1'b1;
      step();
      spur_a = 1'b0;
      repeat (4) step();
      chk("spurious_done_busy", busy_a, 0);
      chk("spurious_done_pulses", pulses_a - base_a, 4);
      main_tab();
      search(1'b0, {$urandom, $urandom, $urandom}, 8'd150, 1'b0, "after_reset");

      // start held high through DONE, then a fresh search with new header/target.
      search(1'b0, {$urandom, $urandom, $urandom}, 8'd150, 1'b1, "hold");
      for (int i = 0; i < 8; i++) hash_tab[i] = 24'($urandom);
      search(1'b0, {$urandom, $urandom, $urandom}, 8'($urandom_range(1, 255)), 1'b0, "relaunch");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
